// File: rtl/my_decoder_pkg.sv
// Shared widths and types for the my_decoder slice.
// Optional hit counters are enabled by defining MY_DECODER_STATS_EN.
package my_decoder_pkg;

    localparam int IN_W_DEF  = 2;
    localparam int CNT_W_DEF = 8;

    function automatic int out_w(input int in_w);
        return 1 << in_w;
    endfunction

    localparam int OUT_W_DEF = out_w(IN_W_DEF);

    typedef logic [OUT_W_DEF-1:0] onehot_t;

endpackage

// File: rtl/my_decoder_onehot.sv
// Combinational binary-to-one-hot decode.
// The shift form makes an unknown select propagate as all-X instead of a wrong one-hot.
module my_decoder_onehot
    import my_decoder_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = out_w(IN_W)
) (
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);

    assign out = OUT_W'(1) << in;

endmodule

// File: rtl/my_decoder.sv
// Decoder with a combinational one-hot output and a registered copy.
// Defining MY_DECODER_STATS_EN adds saturating per-code hit counters readable via rd_sel.
module my_decoder
    import my_decoder_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IN_W-1:0]          in,
    input  logic                     in_valid,
    output logic [out_w(IN_W)-1:0]   out,
    output logic [out_w(IN_W)-1:0]   out_q,
    output logic                     out_q_valid,
    input  logic [IN_W-1:0]          rd_sel,
    output logic [CNT_W-1:0]         rd_hits
);

    localparam int OUT_W = out_w(IN_W);

    logic [OUT_W-1:0] dec;

    my_decoder_onehot #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_onehot (
        .in  (in),
        .out (dec)
    );

    assign out = dec;

    // in_valid is a plain qualifier: no backpressure, a decode is captured on every
    // qualified edge; out_q holds its last decode while out_q_valid drops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q       <= '0;
            out_q_valid <= 1'b0;
        end else begin
            out_q_valid <= in_valid;
            if (in_valid) begin
                out_q <= dec;
            end
        end
    end

`ifdef MY_DECODER_STATS_EN
    logic [CNT_W-1:0] hits [OUT_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < OUT_W; i++) begin
            if (!reset) begin
                hits[i] <= '0;
            end else if (in_valid && in == IN_W'(i) && hits[i] != '1) begin
                hits[i] <= hits[i] + 1'b1;
            end
        end
    end

    assign rd_hits = hits[rd_sel];
`else
    logic unused_rd_sel;

    assign unused_rd_sel = ^rd_sel;
    assign rd_hits       = '0;
`endif

endmodule

// File: tb/tb_my_decoder.sv
// Directed bench for my_decoder; hit-counter expectations follow MY_DECODER_STATS_EN.
module tb_my_decoder;

    localparam int IN_W  = 2;
    localparam int CNT_W = 8;
    localparam int OUT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [IN_W-1:0]  in;
    logic             in_valid;
    logic [OUT_W-1:0] out;
    logic [OUT_W-1:0] out_q;
    logic             out_q_valid;
    logic [IN_W-1:0]  rd_sel;
    logic [CNT_W-1:0] rd_hits;

    int checks = 0;
    int errors = 0;

    my_decoder #(
        .IN_W  (IN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .in_valid    (in_valid),
        .out         (out),
        .out_q       (out_q),
        .out_q_valid (out_q_valid),
        .rd_sel      (rd_sel),
        .rd_hits     (rd_hits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [OUT_W-1:0] exp_q;
    logic [OUT_W-1:0] exp_dec;
    logic [CNT_W-1:0] exp_hits;

    initial begin
        reset    = 1'b1;
        in       = '0;
        in_valid = 1'b0;
        rd_sel   = '0;

        // combinational decode, no edge involved
        in = 2'b00; #1; check("comb_00", 32'(out), 32'b0001);
        in = 2'b01; #1; check("comb_01", 32'(out), 32'b0010);
        in = 2'b10; #1; check("comb_10", 32'(out), 32'b0100);
        in = 2'b11; #1; check("comb_11", 32'(out), 32'b1000);

        // reset held for three edges
        reset = 1'b0;
        @(negedge clk);
        step(); step(); step();
        check("rst_out_q", 32'(out_q), 32'h0);
        check("rst_out_q_valid", 32'(out_q_valid), 32'h0);
        check("rst_hits", 32'(rd_hits), 32'h0);

        // first registered decode
        reset = 1'b1; in = 2'b10; in_valid = 1'b1;
        #1;
        check("pre_out_q", 32'(out_q), 32'h0);
        check("pre_out_q_valid", 32'(out_q_valid), 32'h0);
        step();
        check("reg_10_out_q", 32'(out_q), 32'b0100);
        check("reg_10_valid", 32'(out_q_valid), 32'h1);

        // load 11, then drop valid: out_q holds, out follows in at once
        in = 2'b11; in_valid = 1'b1;
        step();
        check("reg_11_out_q", 32'(out_q), 32'b1000);
        check("reg_11_valid", 32'(out_q_valid), 32'h1);
        in = 2'b01; in_valid = 1'b0;
        #1;
        check("hold_comb_out", 32'(out), 32'b0010);
        step();
        check("hold_out_q", 32'(out_q), 32'b1000);
        check("hold_valid", 32'(out_q_valid), 32'h0);

        // reset wins over in_valid; out unaffected by reset
        reset = 1'b0; in = 2'b10; in_valid = 1'b1;
        step();
        check("rst_prio_out_q", 32'(out_q), 32'h0);
        check("rst_prio_valid", 32'(out_q_valid), 32'h0);
        check("rst_comb_out", 32'(out), 32'b0100);

        // hit counters: 3 hits, then saturate after 300
        reset = 1'b1; in = 2'b01; in_valid = 1'b1; rd_sel = 2'b01;
        for (int i = 0; i < 3; i++) step();
`ifdef MY_DECODER_STATS_EN
        exp_hits = 8'd3;
`else
        exp_hits = 8'd0;
`endif
        check("hits_3", 32'(rd_hits), 32'(exp_hits));
        for (int i = 0; i < 297; i++) step();
`ifdef MY_DECODER_STATS_EN
        exp_hits = 8'd255;
`else
        exp_hits = 8'd0;
`endif
        check("hits_sat", 32'(rd_hits), 32'(exp_hits));
        rd_sel = 2'b00; #1;
        check("hits_other", 32'(rd_hits), 32'h0);
        check("sat_out_q", 32'(out_q), 32'b0010);

        // random traffic against a reference register
        exp_q = out_q;
        for (int i = 0; i < 1000; i++) begin
            in       = IN_W'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            exp_dec  = '0;
            exp_dec[in] = 1'b1;
            #1;
            check("rand_out", 32'(out), 32'(exp_dec));
            if (in_valid) exp_q = exp_dec;
            step();
            check("rand_out_q", 32'(out_q), 32'(exp_q));
            check("rand_onehot0", 32'($onehot0(out_q)), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/my_decoder.md
MY_DECODER -- requirements
Module: my_decoder

Interface
REQ-001 Parameter IN_W, default 2: select width; legal range 1..6.
REQ-002 Parameter CNT_W, default 8: hit-counter width (used only with MY_DECODER_STATS_EN).
REQ-003 Derived constant OUT_W = 2**IN_W (default 4); not overridable.
REQ-004 Clock and reset: clock clk; reset reset, synchronous, active-low.
REQ-005 Port list:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low.
- in  input  IN_W  code to decode.
- in_valid  input  1  qualifies in for the registered path and counters.
- out  output  OUT_W  combinational one-hot decode of in.
- out_q  output  OUT_W  registered one-hot decode.
- out_q_valid  output  1  out_q holds a decode.
- rd_sel  input  IN_W  hit-counter select (stats build only).
- rd_hits  output  CNT_W  hit count for rd_sel (stats build only).

Function
REQ-006 out SHALL equal 1<<in at all times: exactly bit[in] high, all others low. Example: 00->0001, 01->0010, 10->0100, 11->1000.
REQ-007 out SHALL be purely combinational, with zero latency. It SHALL be independent of clk, reset, in_valid and rd_sel, so it works with those inputs unconnected.
REQ-008 If any bit of in is X/Z, out SHALL be all-X in simulation. It SHALL never be a wrong one-hot value.
REQ-009 On each posedge clk with reset=1 and in_valid=1: out_q SHALL load 1<<in, and out_q_valid SHALL load 1. Latency is 1 cycle.
REQ-010 On each posedge clk with reset=1 and in_valid=0: out_q SHALL hold its value, and out_q_valid SHALL load 0.
REQ-011 out_q SHALL always be zero or one-hot. It SHALL never have more than one bit set.

Reset
REQ-012 On a posedge clk with reset=0: out_q SHALL become 0, out_q_valid SHALL become 0, and all hit counters SHALL become 0.
REQ-013 Reset SHALL take priority over in_valid in the same cycle.
REQ-014 Reset SHALL have no effect on out.

Configuration
REQ-015 Macro MY_DECODER_STATS_EN SHALL control the per-code hit counters.
REQ-016 With MY_DECODER_STATS_EN defined:
- One CNT_W-bit counter per output code.
- The counter for in increments on each posedge with reset=1 and in_valid=1.
- Counters saturate at all-ones.
- rd_hits SHALL show the counter selected by rd_sel combinationally.
- Each counter reflects an increment one cycle after the qualifying edge.
REQ-017 Without MY_DECODER_STATS_EN:
- No counters are built.
- rd_sel is ignored.
- rd_hits SHALL be tied to 0.
- Port list is unchanged.

Structure
REQ-018 Package my_decoder_pkg SHALL hold:
- IN_W default, OUT_W derivation function, CNT_W default.
- A onehot_t typedef of width OUT_W.
REQ-019 Sub-module my_decoder_onehot SHALL implement the combinational in->one-hot function.
REQ-020 my_decoder SHALL instantiate my_decoder_onehot once and feed both out and the out_q register from that single instance.

Verification
REQ-021 Exhaustive combinational check, all four in values, clk idle: out = 0001, 0010, 0100, 1000 respectively within #1.
REQ-022 reset=0 for 3 edges, then reset=1, in=10, in_valid=1: out_q=0100 and out_q_valid=1 one edge later. Before that, both are 0.
REQ-023 in=11 with in_valid=1 for one edge, then in_valid=0 with in=01: out_q holds 1000, out_q_valid drops to 0, and out immediately shows 0010.
REQ-024 reset=0 and in_valid=1 on the same edge: out_q=0000 and out_q_valid=0.
REQ-025 Stats build, CNT_W=8: in=01 valid for 300 cycles gives rd_sel=01 -> rd_hits=255 (saturated) and rd_sel=00 -> 0. Non-stats build gives rd_hits=0.
REQ-026 Random in for 1000 cycles: out is always one-hot with out==1<<in, and out_q is always zero or one-hot.
